// File: rtl/uart_echo_pkg.sv
// rtl/uart_echo_pkg.sv - shared encodings for the buffered UART echo engine
package uart_echo_pkg;

  localparam logic [1:0] MODE_RAW   = 2'b00;
  localparam logic [1:0] MODE_UPPER = 2'b01;
  localparam logic [1:0] MODE_SINK  = 2'b10;
  localparam logic [1:0] MODE_CRLF  = 2'b11;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } tx_state_t;

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= 8'h61) && (b <= 8'h7A);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous FIFO with flush and occupancy output
module uart_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// rtl/uart_echo_buffer.sv - buffered echo engine between uart_rx and uart_tx
module uart_echo_buffer
  import uart_echo_pkg::*;
#(
  parameter int          PAYLOAD_BITS = 8,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CNT_W        = 16,
  parameter logic [7:0]  LED_RESET    = 8'hF0,
  localparam int         LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    rx_valid,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  input  logic                    rx_break,
  input  logic                    tx_busy,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  output logic [7:0]              led,
  output logic                    overflow,
  output logic [LVL_W-1:0]        fifo_level,
  output logic [CNT_W-1:0]        rx_count,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int LW = (PAYLOAD_BITS < 8) ? PAYLOAD_BITS : 8;

  tx_state_t               state;
  logic                    pend_lf;
  logic                    push;
  logic                    pop;
  logic                    refused;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [PAYLOAD_BITS-1:0] head;
  logic [PAYLOAD_BITS-1:0] xform;

  // A break flushes the queue, so suppress any push or pop in that cycle.
  assign push    = rx_valid && (mode != MODE_SINK) && !rx_break;
  assign pop     = (state == ST_IDLE) && !pend_lf && !fifo_empty && !tx_busy && !rx_break;
  assign refused = push && fifo_full && !pop;

  uart_byte_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (rx_break),
    .din   (rx_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    xform = head;
    if (PAYLOAD_BITS == 8 && mode == MODE_UPPER && is_lower(8'(head)))
      xform = head - PAYLOAD_BITS'(8'h20);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led        <= LED_RESET;
      overflow   <= 1'b0;
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (rx_valid) begin
        led <= 8'(rx_data[LW-1:0]);
        if (rx_count != '1) rx_count <= rx_count + 1'b1;
      end
      if (refused) overflow <= 1'b1;
      if ((refused || rx_break) && drop_count != '1)
        drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
      pend_lf <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pend_lf && !rx_break) begin
            tx_data <= PAYLOAD_BITS'(ASCII_LF);
            pend_lf <= 1'b0;
            tx_en   <= 1'b1;
            state   <= ST_SEND;
          end else if (pop) begin
            tx_data <= xform;
            pend_lf <= (mode == MODE_CRLF) && (head == PAYLOAD_BITS'(ASCII_CR));
            tx_en   <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND:      state <= ST_WAIT_ACK;
        ST_WAIT_ACK:  if (tx_busy)  state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!tx_busy) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
      if (rx_break) pend_lf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb/tb_uart_echo_buffer.sv - directed self-checking bench for uart_echo_buffer
module tb_uart_echo_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_break;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [7:0]  led;
  logic        overflow;
  logic [4:0]  fifo_level;
  logic [15:0] rx_count;
  logic [15:0] drop_count;

  int          checks = 0;
  int          failures = 0;
  logic        hold_busy = 1'b0;
  int          busy_cnt = 0;
  logic [7:0]  txq [$];

  uart_echo_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_break   (rx_break),
    .tx_busy    (tx_busy),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .led        (led),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .rx_count   (rx_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: records each started byte and stays busy for 3 cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_en === 1'b1) begin
        txq.push_back(tx_data);
        busy_cnt = 3;
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
      end
      tx_busy = hold_busy || (busy_cnt > 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      if (fifo_level == 0 && !tx_busy && !tx_en) quiet++;
      else quiet = 0;
    end
    chk("quiet_timeout", 32'(quiet >= 4), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tx_en"},    32'(tx_en),      32'h0);
    chk({tag, "_tx_data"},  32'(tx_data),    32'h0);
    chk({tag, "_led"},      32'(led),        32'hF0);
    chk({tag, "_overflow"}, 32'(overflow),   32'h0);
    chk({tag, "_level"},    32'(fifo_level), 32'h0);
    chk({tag, "_rx_count"}, 32'(rx_count),   32'h0);
    chk({tag, "_drop"},     32'(drop_count), 32'h0);
  endtask

  initial begin
    logic [7:0] exp_up [3];
    logic [7:0] exp_cr [3];
    int n;
    exp_up = '{8'h41, 8'h5A, 8'h5B};
    exp_cr = '{8'h0D, 8'h0A, 8'h31};
    rst = 1'b1; mode = 2'b00; rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0;
    idle_cycles(3);
    rst = 1'b0;
    chk_reset_state("reset");

    // Single byte latency
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h41;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("lat_en_early", 32'(tx_en), 32'h0);
    chk("lat_level1",   32'(fifo_level), 32'h1);
    chk("lat_led",      32'(led), 32'h41);
    chk("lat_rx_count", 32'(rx_count), 32'h1);
    @(negedge clk);
    chk("lat_en",       32'(tx_en), 32'h1);
    chk("lat_data",     32'(tx_data), 32'h41);
    chk("lat_level0",   32'(fifo_level), 32'h0);
    wait_quiet();
    chk("lat_qsize", 32'(txq.size()), 32'h1);

    // Upper-case mode
    txq = {};
    mode = 2'b01;
    send_byte(8'h61); send_byte(8'h7A); send_byte(8'h5B);
    wait_quiet();
    chk("up_qsize", 32'(txq.size()), 32'h3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("up_byte%0d", i), 32'((i < txq.size()) ? txq[i] : 8'hxx), 32'(exp_up[i]));

    // CR -> CR,LF mode
    txq = {};
    mode = 2'b11;
    send_byte(8'h0D); send_byte(8'h31);
    wait_quiet();
    chk("cr_qsize", 32'(txq.size()), 32'h3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("cr_byte%0d", i), 32'((i < txq.size()) ? txq[i] : 8'hxx), 32'(exp_cr[i]));
    chk("cr_level", 32'(fifo_level), 32'h0);
    chk("cr_rx_count", 32'(rx_count), 32'h6);

    // Overflow with TX held busy
    txq = {};
    mode = 2'b00;
    hold_busy = 1'b1;
    idle_cycles(2);
    rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("ovf_level",    32'(fifo_level), 32'd16);
    chk("ovf_flag",     32'(overflow), 32'h1);
    chk("ovf_drop",     32'(drop_count), 32'h1);
    chk("ovf_rx_count", 32'(rx_count), 32'd23);
    chk("ovf_no_tx",    32'(txq.size()), 32'h0);
    hold_busy = 1'b0;
    wait_quiet();
    chk("ovf_qsize", 32'(txq.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("ovf_byte%0d", i), 32'((i < txq.size()) ? txq[i] : 8'hxx), 32'h10 + 32'(i));

    // Break flushes queued bytes; in-flight byte completes
    txq = {};
    @(negedge clk);
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'h50 + 8'(i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("brk_level_pre", 32'(fifo_level), 32'h4);
    rx_break = 1'b1;
    @(negedge clk);
    rx_break = 1'b0;
    chk("brk_level", 32'(fifo_level), 32'h0);
    chk("brk_drop",  32'(drop_count), 32'h2);
    wait_quiet();
    chk("brk_qsize", 32'(txq.size()), 32'h1);
    chk("brk_inflight", 32'((txq.size() > 0) ? txq[0] : 8'hxx), 32'h50);

    // Break and byte in the same cycle
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h77; rx_break = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_break = 1'b0;
    chk("bv_led",      32'(led), 32'h77);
    chk("bv_rx_count", 32'(rx_count), 32'd29);
    chk("bv_level",    32'(fifo_level), 32'h0);
    chk("bv_drop",     32'(drop_count), 32'h3);
    wait_quiet();
    chk("bv_qsize", 32'(txq.size()), 32'h1);

    // Sink mode
    do_reset();
    txq = {};
    mode = 2'b10;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    idle_cycles(8);
    chk("sink_qsize",    32'(txq.size()), 32'h0);
    chk("sink_led",      32'(led), 32'hA3);
    chk("sink_rx_count", 32'(rx_count), 32'h3);
    chk("sink_level",    32'(fifo_level), 32'h0);

    // Reset while waiting for the transmitter to finish
    mode = 2'b00;
    send_byte(8'h55);
    n = 0;
    while (tx_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_en_seen", 32'(tx_en), 32'h1);
    hold_busy = 1'b1;
    idle_cycles(3);
    do_reset();
    chk_reset_state("mid_rst");
    send_byte(8'h66);
    idle_cycles(5);
    chk("mid_no_tx",  32'(txq.size()), 32'h1);
    chk("mid_level1", 32'(fifo_level), 32'h1);
    hold_busy = 1'b0;
    wait_quiet();
    chk("mid_qsize", 32'(txq.size()), 32'h2);
    chk("mid_byte",  32'((txq.size() > 1) ? txq[1] : 8'hxx), 32'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
